riscv_test_monitor: RTL and testbench

Synthesizable self-check monitor for the RISC-V core: holds a programmable table of (instruction-count milestone, expected OUTPUT_PORT value, compare mask) entries and checks the core's OUTPUT_PORT each time NUM_INST reaches the next milestone. It sits beside RISCV_TOP on the core's NUM_INST, OUTPUT_PORT and HALT signals and produces a registered verdict plus diagnostics. It extends the fixed-table bench checker with the following:
- parametrised test count and data width;
- per-entry compare masks;
- detection of missed milestones and premature HALT;
- a hang watchdog.

---
 rtl/riscv_test_monitor.sv | 170 +++++++++++++++++
 tb/tb_riscv_test_monitor.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_monitor.sv
// Self-check monitor for the RISC-V core: compares OUTPUT_PORT against a programmable
// table of (milestone, expected value, mask) entries as NUM_INST advances.
module riscv_test_monitor #(
    parameter int NUM_TEST = 32,
    parameter int IDX_W    = 5,
    parameter int DWIDTH   = 32,
    parameter int TIMEOUT  = 100000,
    parameter int CNT_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CFG_WE,
    input  logic [IDX_W-1:0]  CFG_IDX,
    input  logic [DWIDTH-1:0] CFG_NUM_INST,
    input  logic [DWIDTH-1:0] CFG_ANS,
    input  logic [DWIDTH-1:0] CFG_MASK,
    input  logic [IDX_W:0]    CFG_LEN,
    input  logic              START,
    input  logic              CLEAR,
    input  logic [DWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic [2:0]        STATUS,
    output logic [1:0]        FAIL_CAUSE,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_VALUE,
    output logic [IDX_W:0]    PASS_CNT,
    output logic [CNT_W-1:0]  CYCLE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PASS    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    localparam logic [1:0] C_NONE     = 2'd0;
    localparam logic [1:0] C_MISMATCH = 2'd1;
    localparam logic [1:0] C_MISSED   = 2'd2;
    localparam logic [1:0] C_HALT     = 2'd3;

    localparam logic [IDX_W:0]   MAX_LEN    = (IDX_W+1)'(NUM_TEST);
    localparam logic [IDX_W:0]   ONE_IDX    = (IDX_W+1)'(1);
    localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
    localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WDOG_MAX   = '1;

    logic [DWIDTH-1:0] tbl_num  [NUM_TEST];
    logic [DWIDTH-1:0] tbl_ans  [NUM_TEST];
    logic [DWIDTH-1:0] tbl_mask [NUM_TEST];

    logic [2:0]        state;
    logic [IDX_W:0]    ptr;
    logic [IDX_W:0]    len;
    logic [CNT_W-1:0]  wdog;
    logic [DWIDTH-1:0] prev_num;

    logic [IDX_W-1:0]  rd_idx;
    logic [DWIDTH-1:0] e_num;
    logic [DWIDTH-1:0] e_ans;
    logic [DWIDTH-1:0] e_mask;
    logic              active;
    logic              hit;
    logic              match;
    logic              missed;
    logic [IDX_W:0]    ptr_next;
    logic [CNT_W-1:0]  wdog_next;

    assign STATUS = state;
    assign rd_idx = ptr[IDX_W-1:0];
    assign e_num  = tbl_num[rd_idx];
    assign e_ans  = tbl_ans[rd_idx];
    assign e_mask = tbl_mask[rd_idx];

    // ptr_next is the pointer after this cycle's compare; HALT is judged against it so a
    // final milestone passing together with HALT still counts as a pass.
    always_comb begin
        active    = (ptr < len);
        hit       = active && (NUM_INST == e_num);
        match     = ((OUTPUT_PORT ^ e_ans) & e_mask) == '0;
        missed    = active && (NUM_INST > e_num);
        ptr_next  = (hit && match) ? ptr + ONE_IDX : ptr;
        wdog_next = wdog;
        if (NUM_INST != prev_num) begin
            wdog_next = '0;
        end else if (wdog != WDOG_MAX) begin
            wdog_next = wdog + ONE_CNT;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && state == S_IDLE && CFG_WE) begin
            tbl_num[CFG_IDX]  <= CFG_NUM_INST;
            tbl_ans[CFG_IDX]  <= CFG_ANS;
            tbl_mask[CFG_IDX] <= CFG_MASK;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            ptr        <= '0;
            len        <= '0;
            wdog       <= '0;
            prev_num   <= '0;
            FAIL_CAUSE <= C_NONE;
            FAIL_IDX   <= '0;
            FAIL_VALUE <= '0;
            PASS_CNT   <= '0;
            CYCLE      <= '0;
        end else begin
            prev_num <= NUM_INST;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        len      <= (CFG_LEN > MAX_LEN) ? MAX_LEN : CFG_LEN;
                        ptr      <= '0;
                        PASS_CNT <= '0;
                        CYCLE    <= '0;
                        wdog     <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    CYCLE <= CYCLE + ONE_CNT;
                    wdog  <= wdog_next;
                    ptr   <= ptr_next;
                    if (hit && match) begin
                        PASS_CNT <= PASS_CNT + ONE_IDX;
                    end
                    if (hit && !match) begin
                        state      <= S_FAIL;
                        FAIL_CAUSE <= C_MISMATCH;
                        FAIL_IDX   <= ptr_next[IDX_W-1:0];
                        FAIL_VALUE <= OUTPUT_PORT;
                    end else if (missed) begin
                        state      <= S_FAIL;
                        FAIL_CAUSE <= C_MISSED;
                        FAIL_IDX   <= ptr_next[IDX_W-1:0];
                        FAIL_VALUE <= OUTPUT_PORT;
                    end else if (HALT && ptr_next == len) begin
                        state <= S_PASS;
                    end else if (HALT) begin
                        state      <= S_FAIL;
                        FAIL_CAUSE <= C_HALT;
                        FAIL_IDX   <= ptr_next[IDX_W-1:0];
                        FAIL_VALUE <= OUTPUT_PORT;
                    end else if (wdog_next >= WDOG_LIMIT) begin
                        state <= S_TIMEOUT;
                    end
                end
                default: begin
                    // Terminal states; the table survives CLEAR, everything else is zeroed.
                    if (CLEAR) begin
                        state      <= S_IDLE;
                        ptr        <= '0;
                        len        <= '0;
                        wdog       <= '0;
                        FAIL_CAUSE <= C_NONE;
                        FAIL_IDX   <= '0;
                        FAIL_VALUE <= '0;
                        PASS_CNT   <= '0;
                        CYCLE      <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: per-cycle vector tables with a scoreboard of
// expected verdicts, plus hand-driven CLEAR, RST and configuration sequences.
`timescale 1ns/1ps
module tb_riscv_test_monitor;

    localparam int IDX_W  = 5;
    localparam int DWIDTH = 32;
    localparam int CNT_W  = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              CFG_WE = 1'b0;
    logic [IDX_W-1:0]  CFG_IDX = '0;
    logic [DWIDTH-1:0] CFG_NUM_INST = '0;
    logic [DWIDTH-1:0] CFG_ANS = '0;
    logic [DWIDTH-1:0] CFG_MASK = '0;
    logic [IDX_W:0]    CFG_LEN = '0;
    logic              START = 1'b0;
    logic              CLEAR = 1'b0;
    logic [DWIDTH-1:0] NUM_INST = '0;
    logic [DWIDTH-1:0] OUTPUT_PORT = '0;
    logic              HALT = 1'b0;
    logic [2:0]        STATUS;
    logic [1:0]        FAIL_CAUSE;
    logic [IDX_W-1:0]  FAIL_IDX;
    logic [DWIDTH-1:0] FAIL_VALUE;
    logic [IDX_W:0]    PASS_CNT;
    logic [CNT_W-1:0]  CYCLE;

    riscv_test_monitor #(
        .NUM_TEST(32), .IDX_W(IDX_W), .DWIDTH(DWIDTH), .TIMEOUT(10), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
        .CFG_NUM_INST(CFG_NUM_INST), .CFG_ANS(CFG_ANS), .CFG_MASK(CFG_MASK),
        .CFG_LEN(CFG_LEN), .START(START), .CLEAR(CLEAR), .NUM_INST(NUM_INST),
        .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .STATUS(STATUS),
        .FAIL_CAUSE(FAIL_CAUSE), .FAIL_IDX(FAIL_IDX), .FAIL_VALUE(FAIL_VALUE),
        .PASS_CNT(PASS_CNT), .CYCLE(CYCLE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] num;
        logic [31:0] outp;
        logic        halt;
        logic [2:0]  st;
        logic [1:0]  cause;
        logic [4:0]  fidx;
        logic [31:0] fval;
        logic [5:0]  pcnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [1:0]  cause;
        logic [4:0]  fidx;
        logic [31:0] fval;
        logic [5:0]  pcnt;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] expCycle = '0;
    logic [2:0]  prevExpSt = ST_IDLE;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic void addVec(logic [31:0] num, logic [31:0] outp, logic halt, logic [2:0] st,
                                   logic [1:0] cause, logic [4:0] fidx, logic [31:0] fval,
                                   logic [5:0] pcnt);
        vec_t v;
        v.num = num; v.outp = outp; v.halt = halt; v.st = st;
        v.cause = cause; v.fidx = fidx; v.fval = fval; v.pcnt = pcnt;
        vecs.push_back(v);
    endfunction

    function automatic void expectState(string name, logic [2:0] st, logic [1:0] cause,
                                        logic [4:0] fidx, logic [31:0] fval, logic [5:0] pcnt,
                                        logic [31:0] cyc);
        exp_t e;
        e.name = name; e.st = st; e.cause = cause; e.fidx = fidx;
        e.fval = fval; e.pcnt = pcnt; e.cyc = cyc;
        sb.push_back(e);
    endfunction

    function automatic void cmpField(string name, string field, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, req);
        end
    endfunction

    // Pops the oldest expectation and compares it with the registered outputs.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        cmpField(e.name, "STATUS",     32'(STATUS),     32'(e.st));
        cmpField(e.name, "FAIL_CAUSE", 32'(FAIL_CAUSE), 32'(e.cause));
        cmpField(e.name, "FAIL_IDX",   32'(FAIL_IDX),   32'(e.fidx));
        cmpField(e.name, "FAIL_VALUE", FAIL_VALUE,      e.fval);
        cmpField(e.name, "PASS_CNT",   32'(PASS_CNT),   32'(e.pcnt));
        cmpField(e.name, "CYCLE",      CYCLE,           e.cyc);
    endtask

    // CYCLE advances on every edge that finds the monitor in RUN, including the verdict edge.
    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        NUM_INST = v.num;
        OUTPUT_PORT = v.outp;
        HALT = v.halt;
        if (prevExpSt == ST_RUN) expCycle = expCycle + 32'd1;
        e.name = name; e.st = v.st; e.cause = v.cause; e.fidx = v.fidx;
        e.fval = v.fval; e.pcnt = v.pcnt; e.cyc = expCycle;
        sb.push_back(e);
        prevExpSt = v.st;
        tick();
        checkOutput();
    endtask

    task automatic runVectors(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("%s[%0d]", name, i));
        end
        vecs.delete();
    endtask

    task automatic writeEntry(input logic [4:0] idx, input logic [31:0] num,
                              input logic [31:0] ans, input logic [31:0] mask);
        CFG_WE = 1'b1; CFG_IDX = idx; CFG_NUM_INST = num; CFG_ANS = ans; CFG_MASK = mask;
        tick();
        CFG_WE = 1'b0;
    endtask

    task automatic startRun(input logic [5:0] len, input string name);
        CFG_LEN = len;
        START = 1'b1;
        tick();
        START = 1'b0;
        expCycle = '0;
        prevExpSt = ST_RUN;
        expectState(name, ST_RUN, 2'd0, 5'd0, 32'd0, 6'd0, 32'd0);
        checkOutput();
    endtask

    task automatic doClear(input string name);
        HALT = 1'b0;
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        expCycle = '0;
        prevExpSt = ST_IDLE;
        expectState(name, ST_IDLE, 2'd0, 5'd0, 32'd0, 6'd0, 32'd0);
        checkOutput();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        tick();
        tick();
        RST = 1'b0;
        expectState("reset", ST_IDLE, 2'd0, 5'd0, 32'd0, 6'd0, 32'd0);
        checkOutput();

        writeEntry(5'd0, 32'd1, 32'h0, 32'hFFFF_FFFF);
        writeEntry(5'd1, 32'd3, 32'h5, 32'h0000_FFFF);
        writeEntry(5'd2, 32'd5, 32'h1, 32'hFFFF_FFFF);

        // Full pass with junk in the masked-off upper bits at milestone 3.
        startRun(6'd3, "pass_start");
        addVec(0, 32'h0,         0, ST_RUN,  0, 0, 0, 0);
        addVec(1, 32'h0,         0, ST_RUN,  0, 0, 0, 1);
        addVec(2, 32'h7,         0, ST_RUN,  0, 0, 0, 1);
        addVec(3, 32'hABCD_0005, 0, ST_RUN,  0, 0, 0, 2);
        addVec(4, 32'h9,         0, ST_RUN,  0, 0, 0, 2);
        addVec(5, 32'h1,         0, ST_RUN,  0, 0, 0, 3);
        addVec(5, 32'h1,         1, ST_PASS, 0, 0, 0, 3);
        addVec(6, 32'h0,         1, ST_PASS, 0, 0, 0, 3);
        runVectors("pass");
        doClear("pass_clear");

        // Mismatch at entry 1, then START in FAIL must be ignored.
        startRun(6'd3, "mis_start");
        addVec(0, 32'h0, 0, ST_RUN,  0, 0, 0, 0);
        addVec(1, 32'h0, 0, ST_RUN,  0, 0, 0, 1);
        addVec(2, 32'h0, 0, ST_RUN,  0, 0, 0, 1);
        addVec(3, 32'h4, 0, ST_FAIL, 1, 1, 32'h4, 1);
        addVec(4, 32'h0, 0, ST_FAIL, 1, 1, 32'h4, 1);
        runVectors("mismatch");
        START = 1'b1;
        addVec(4, 32'h0, 0, ST_FAIL, 1, 1, 32'h4, 1);
        runVectors("start_in_fail");
        START = 1'b0;
        doClear("mis_clear");

        // Missed milestone: NUM_INST skips from 2 to 4.
        startRun(6'd3, "missed_start");
        addVec(1, 32'h0,  0, ST_RUN,  0, 0, 0, 1);
        addVec(2, 32'h0,  0, ST_RUN,  0, 0, 0, 1);
        addVec(4, 32'h44, 0, ST_FAIL, 2, 1, 32'h44, 1);
        runVectors("missed");
        doClear("missed_clear");

        // Premature HALT in the same cycle as a pass at milestone 3.
        startRun(6'd3, "halt_start");
        addVec(1, 32'h0, 0, ST_RUN,  0, 0, 0, 1);
        addVec(3, 32'h5, 1, ST_FAIL, 3, 2, 32'h5, 2);
        runVectors("premature_halt");
        doClear("halt_clear");

        // Watchdog: the 10th unchanged sample after the last change times out.
        startRun(6'd3, "wdog_start");
        addVec(1, 32'h0, 0, ST_RUN, 0, 0, 0, 1);
        addVec(2, 32'h0, 0, ST_RUN, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) addVec(2, 32'h0, 0, ST_RUN, 0, 0, 0, 1);
        addVec(2, 32'h0, 0, ST_TIMEOUT, 0, 0, 0, 1);
        runVectors("watchdog");
        doClear("wdog_clear");

        // Milestone held for 3 cycles counts once; HALT with the final milestone passes.
        startRun(6'd3, "hold_start");
        addVec(1, 32'h0, 0, ST_RUN,  0, 0, 0, 1);
        addVec(1, 32'h0, 0, ST_RUN,  0, 0, 0, 1);
        addVec(1, 32'h0, 0, ST_RUN,  0, 0, 0, 1);
        addVec(3, 32'h5, 0, ST_RUN,  0, 0, 0, 2);
        addVec(5, 32'h1, 1, ST_PASS, 0, 0, 0, 3);
        runVectors("hold_halt_last");
        doClear("hold_clear");

        // A table write attempted during RUN must not land.
        startRun(6'd3, "cfgrun_start");
        CFG_WE = 1'b1; CFG_IDX = 5'd1; CFG_NUM_INST = 32'd3; CFG_ANS = 32'h99; CFG_MASK = '1;
        addVec(1, 32'h0, 0, ST_RUN, 0, 0, 0, 1);
        runVectors("cfg_in_run");
        CFG_WE = 1'b0;
        addVec(2, 32'h0, 1, ST_FAIL, 3, 1, 32'h0, 1);
        runVectors("cfg_in_run_halt");
        doClear("cfgrun_clear");
        startRun(6'd3, "rerun_start");
        addVec(1, 32'h0,         0, ST_RUN,  0, 0, 0, 1);
        addVec(3, 32'hABCD_0005, 0, ST_RUN,  0, 0, 0, 2);
        addVec(5, 32'h1,         1, ST_PASS, 0, 0, 0, 3);
        runVectors("rerun");
        doClear("rerun_clear");

        // Synchronous reset in the middle of a run.
        startRun(6'd3, "rst_start");
        addVec(1, 32'h0, 0, ST_RUN, 0, 0, 0, 1);
        addVec(3, 32'h5, 0, ST_RUN, 0, 0, 0, 2);
        runVectors("pre_reset");
        RST = 1'b1;
        tick();
        RST = 1'b0;
        expCycle = '0;
        prevExpSt = ST_IDLE;
        expectState("mid_run_reset", ST_IDLE, 2'd0, 5'd0, 32'd0, 6'd0, 32'd0);
        checkOutput();

        // Empty table: HALT alone is a pass.
        startRun(6'd0, "len0_start");
        addVec(3, 32'h0, 1, ST_PASS, 0, 0, 0, 0);
        runVectors("len0_halt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
